// File: rtl/scm_adapter_pkg.sv
// Shared types for the SCM 1R/1W adapter.
//   resp_t    : one queued read response (data word).
//   fwd_t     : forwarding record for a same-cycle, same-address read/write pair.
//   ptr_width : pointer width needed to index a FIFO of the given depth.
// The struct widths are fixed at SCM_DATA_W; the adapter's DATA_WIDTH
// parameter defaults to this value and must be kept equal to it.
package scm_adapter_pkg;

  localparam int unsigned SCM_DATA_W = 32;
  localparam int unsigned SCM_BE_W   = SCM_DATA_W / 8;

  typedef struct packed {
    logic [SCM_DATA_W-1:0] data;
  } resp_t;

  typedef struct packed {
    logic                  hit;
    logic [SCM_BE_W-1:0]   be;
    logic [SCM_DATA_W-1:0] data;
  } fwd_t;

  function automatic int unsigned ptr_width(input int unsigned depth);
    return (depth <= 1) ? 1 : $clog2(depth);
  endfunction

endpackage

// File: rtl/scm_resp_fifo.sv
// Response FIFO for the SCM adapter: DEPTH entries of resp_t, head is shown
// combinationally on rdata_o (zero while empty).
// Ports:
//   clk, rst_n         clock, asynchronous active-low reset
//   push_i, wdata_i    enqueue (caller guarantees space, or a same-cycle pop)
//   pop_i              dequeue the head; ignored while empty
//   rdata_o            head entry
//   count_o            number of valid entries
//   full_o, empty_o    occupancy flags
module scm_resp_fifo
  import scm_adapter_pkg::*;
#(
  parameter int unsigned DEPTH = 2
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         push_i,
  input  resp_t                        wdata_i,
  input  logic                         pop_i,
  output resp_t                        rdata_o,
  output logic [$clog2(DEPTH+1)-1:0]   count_o,
  output logic                         full_o,
  output logic                         empty_o
);

  localparam int unsigned PW = ptr_width(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH + 1);

  resp_t         mem_q [DEPTH];
  logic [PW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CW-1:0] count_q, count_d;
  logic          do_push, do_pop;

  function automatic logic [PW-1:0] inc_ptr(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign do_push = push_i;
  assign do_pop  = pop_i & ~empty_o;

  always_comb begin
    count_d = count_q;
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= inc_ptr(wr_ptr_q);
      if (do_pop)  rd_ptr_q <= inc_ptr(rd_ptr_q);
      count_q <= count_d;
    end
  end

  // Storage needs no reset: the head is masked while the FIFO is empty.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata_i;
  end

  assign count_o = count_q;
  assign full_o  = (count_q == CW'(DEPTH));
  assign empty_o = (count_q == '0);
  assign rdata_o = empty_o ? '0 : mem_q[rd_ptr_q];

endmodule

// File: rtl/scm_1r_1w_adapter.sv
// Request/response front-end for the latch-based 1R/1W SCM.
// Turns a TCDM-style read port and write port into raw SCM controls and
// returns read data in order through a credit-checked response FIFO.
// Optional feature macro: SCM_ADAPTER_FWD_EN
//   defined   : same-cycle same-address write data is merged into the read
//               response byte-wise; read grant ignores addresses.
//   undefined : such a read is held off one cycle instead.
// Ports:
//   clk, rst_n                         clock, asynchronous active-low reset
//   rd_req_i/rd_gnt_o/rd_add_i         read request, grant, word address
//   rd_rvalid_o/rd_rdata_o/rd_rready_i read response handshake
//   wr_req_i/wr_gnt_o/wr_add_i         write request, grant, word address
//   wr_wdata_i/wr_be_i                 write data, byte enables
//   scm_ren_o/scm_raddr_o/scm_rdata_i  SCM read port
//   scm_wen_o/scm_waddr_o/scm_wdata_o/scm_wbe_o  SCM write port
module scm_1r_1w_adapter
  import scm_adapter_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 5,
  parameter int unsigned DATA_WIDTH = SCM_DATA_W,
  parameter int unsigned RESP_DEPTH = 2
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    rd_req_i,
  output logic                    rd_gnt_o,
  input  logic [ADDR_WIDTH-1:0]   rd_add_i,
  output logic                    rd_rvalid_o,
  output logic [DATA_WIDTH-1:0]   rd_rdata_o,
  input  logic                    rd_rready_i,
  input  logic                    wr_req_i,
  output logic                    wr_gnt_o,
  input  logic [ADDR_WIDTH-1:0]   wr_add_i,
  input  logic [DATA_WIDTH-1:0]   wr_wdata_i,
  input  logic [DATA_WIDTH/8-1:0] wr_be_i,
  output logic                    scm_ren_o,
  output logic [ADDR_WIDTH-1:0]   scm_raddr_o,
  input  logic [DATA_WIDTH-1:0]   scm_rdata_i,
  output logic                    scm_wen_o,
  output logic [ADDR_WIDTH-1:0]   scm_waddr_o,
  output logic [DATA_WIDTH-1:0]   scm_wdata_o,
  output logic [DATA_WIDTH/8-1:0] scm_wbe_o
);

  localparam int unsigned CW = $clog2(RESP_DEPTH + 1);

  logic          inflight_q;
  logic          fifo_push, fifo_pop, fifo_full, fifo_empty;
  logic [CW-1:0] fifo_count;
  resp_t         fifo_head, capture;
  logic          credit_ok, rd_block;

  // Write path: always accepted out of reset.
  assign wr_gnt_o    = rst_n;
  assign scm_wen_o   = wr_req_i & wr_gnt_o;
  assign scm_waddr_o = wr_add_i;
  assign scm_wdata_o = wr_wdata_i;
  assign scm_wbe_o   = wr_be_i;

  // Response handshake and credit: queued + in flight - leaving must stay
  // below the FIFO depth, computed without subtraction to avoid underflow.
  assign fifo_pop  = rd_rvalid_o & rd_rready_i;
  assign credit_ok = (({1'b0, fifo_count} + (CW+1)'(inflight_q))
                      < ((CW+1)'(RESP_DEPTH) + (CW+1)'(fifo_pop)));

  assign rd_gnt_o    = rst_n & rd_req_i & credit_ok & ~rd_block;
  assign scm_ren_o   = rd_gnt_o;
  assign scm_raddr_o = rd_gnt_o ? rd_add_i : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) inflight_q <= 1'b0;
    else        inflight_q <= rd_gnt_o;
  end

`ifdef SCM_ADAPTER_FWD_EN
  fwd_t fwd_d, fwd_q;

  assign rd_block = 1'b0;

  always_comb begin
    fwd_d      = '0;
    fwd_d.hit  = rd_gnt_o & scm_wen_o & (rd_add_i == wr_add_i);
    fwd_d.be   = wr_be_i;
    fwd_d.data = wr_wdata_i;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) fwd_q <= '0;
    else        fwd_q <= fwd_d;
  end

  // The SCM returns the pre-write word for a same-cycle pair; patch in the
  // enabled bytes of the colliding write.
  always_comb begin
    capture.data = scm_rdata_i;
    for (int b = 0; b < DATA_WIDTH / 8; b++) begin
      if (fwd_q.hit && fwd_q.be[b]) capture.data[8*b +: 8] = fwd_q.data[8*b +: 8];
    end
  end
`else
  // Hold a colliding read off by one cycle; the write has landed by then.
  assign rd_block = wr_req_i & rd_req_i & (rd_add_i == wr_add_i);

  always_comb begin
    capture.data = scm_rdata_i;
  end
`endif

  // Space is guaranteed by the credit check; the guard keeps the FIFO safe
  // even if that invariant were ever broken.
  assign fifo_push = inflight_q & (~fifo_full | fifo_pop);

  scm_resp_fifo #(
    .DEPTH(RESP_DEPTH)
  ) u_resp_fifo (
    .clk    (clk),
    .rst_n  (rst_n),
    .push_i (fifo_push),
    .wdata_i(capture),
    .pop_i  (fifo_pop),
    .rdata_o(fifo_head),
    .count_o(fifo_count),
    .full_o (fifo_full),
    .empty_o(fifo_empty)
  );

  assign rd_rvalid_o = ~fifo_empty;
  assign rd_rdata_o  = fifo_head.data;

endmodule

// File: tb/tb_scm_1r_1w_adapter.sv
// Self-checking bench for scm_1r_1w_adapter (default parameters).
// Contains a behavioural SCM (read data registered one cycle after ren,
// byte-enabled write at the clock edge) and an in-order response scoreboard.
// Honours SCM_ADAPTER_FWD_EN for the collision expectations.
module tb_scm_1r_1w_adapter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        rd_req, rd_gnt, rd_rvalid, rd_rready;
  logic [4:0]  rd_add;
  logic [31:0] rd_rdata;
  logic        wr_req, wr_gnt;
  logic [4:0]  wr_add;
  logic [31:0] wr_wdata;
  logic [3:0]  wr_be;
  logic        scm_ren, scm_wen;
  logic [4:0]  scm_raddr, scm_waddr;
  logic [31:0] scm_rdata, scm_wdata;
  logic [3:0]  scm_wbe;

  int n_checks = 0;
  int n_fail   = 0;
  int n_resp   = 0;

  logic [31:0] mem [32];
  logic [31:0] exp_q [$];

  always #5 clk = ~clk;

  scm_1r_1w_adapter dut (
    .clk(clk), .rst_n(rst_n),
    .rd_req_i(rd_req), .rd_gnt_o(rd_gnt), .rd_add_i(rd_add),
    .rd_rvalid_o(rd_rvalid), .rd_rdata_o(rd_rdata), .rd_rready_i(rd_rready),
    .wr_req_i(wr_req), .wr_gnt_o(wr_gnt), .wr_add_i(wr_add),
    .wr_wdata_i(wr_wdata), .wr_be_i(wr_be),
    .scm_ren_o(scm_ren), .scm_raddr_o(scm_raddr), .scm_rdata_i(scm_rdata),
    .scm_wen_o(scm_wen), .scm_waddr_o(scm_waddr), .scm_wdata_o(scm_wdata),
    .scm_wbe_o(scm_wbe)
  );

  // Behavioural SCM.
  always @(posedge clk) begin
    if (scm_ren) scm_rdata <= mem[scm_raddr];
    if (scm_wen)
      for (int b = 0; b < 4; b++)
        if (scm_wbe[b]) mem[scm_waddr][8*b +: 8] <= scm_wdata[8*b +: 8];
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Response scoreboard.
  always @(negedge clk) begin
    if (rst_n && rd_rvalid && rd_rready) begin
      n_resp++;
      if (exp_q.size() == 0) chk("unexpected_resp", rd_rdata, 32'hxxxx_xxxx);
      else chk("resp_data", rd_rdata, exp_q.pop_front());
    end
  end

  // Value a granted read must return given the currently driven write.
  function automatic logic [31:0] model_rd(input logic [4:0] ra, input logic wq,
                                           input logic [4:0] wa, input logic [31:0] wd,
                                           input logic [3:0] be);
    logic [31:0] r;
    r = mem[ra];
    if (wq && wa == ra)
      for (int b = 0; b < 4; b++)
        if (be[b]) r[8*b +: 8] = wd[8*b +: 8];
    return r;
  endfunction

  task automatic expect_read();
    exp_q.push_back(model_rd(rd_add, wr_req, wr_add, wr_wdata, wr_be));
  endtask

  task automatic drive(input logic rq, input logic [4:0] ra, input logic wq,
                       input logic [4:0] wa, input logic [31:0] wd, input logic [3:0] be);
    rd_req = rq; rd_add = ra; wr_req = wq; wr_add = wa; wr_wdata = wd; wr_be = be;
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic idle(input int n);
    drive(1'b0, 5'd0, 1'b0, 5'd0, 32'h0, 4'h0);
    repeat (n) tick();
  endtask

  typedef struct {
    logic        rd_req;
    logic [4:0]  rd_add;
    logic        wr_req;
    logic [4:0]  wr_add;
    logic [31:0] wdata;
    logic [3:0]  be;
    logic        exp_gnt;
    logic        exp_wen;
  } vec_t;

  vec_t vecs [9];

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin : main
    int base, granted, next_a;
    logic [31:0] head20;

    for (int i = 0; i < 32; i++) mem[i] = {8'(i), 8'hA5, 8'(i * 7), 8'h3C ^ 8'(i)};
    mem[7] = 32'h11223344;

    vecs[0] = '{1'b0, 5'd0,  1'b1, 5'd3,  32'hDEADBEEF, 4'hF, 1'b0, 1'b1};
    vecs[1] = '{1'b1, 5'd3,  1'b0, 5'd0,  32'h0,        4'h0, 1'b1, 1'b0};
`ifdef SCM_ADAPTER_FWD_EN
    vecs[2] = '{1'b1, 5'd7,  1'b1, 5'd7,  32'hAABBCCDD, 4'h5, 1'b1, 1'b1};
`else
    vecs[2] = '{1'b1, 5'd7,  1'b1, 5'd7,  32'hAABBCCDD, 4'h5, 1'b0, 1'b1};
`endif
    vecs[3] = '{1'b1, 5'd7,  1'b0, 5'd0,  32'h0,        4'h0, 1'b1, 1'b0};
    vecs[4] = '{1'b1, 5'd10, 1'b1, 5'd9,  32'h01020304, 4'h3, 1'b1, 1'b1};
    vecs[5] = '{1'b0, 5'd4,  1'b0, 5'd4,  32'h12345678, 4'hF, 1'b0, 1'b0};
    vecs[6] = '{1'b1, 5'd9,  1'b0, 5'd0,  32'h0,        4'h0, 1'b1, 1'b0};
`ifdef SCM_ADAPTER_FWD_EN
    vecs[7] = '{1'b1, 5'd9,  1'b1, 5'd9,  32'hFFFFFFFF, 4'h0, 1'b1, 1'b1};
`else
    vecs[7] = '{1'b1, 5'd9,  1'b1, 5'd9,  32'hFFFFFFFF, 4'h0, 1'b0, 1'b1};
`endif
    vecs[8] = '{1'b1, 5'd9,  1'b0, 5'd0,  32'h0,        4'h0, 1'b1, 1'b0};

    // Reset with both requests asserted.
    rst_n = 1'b0;
    rd_rready = 1'b1;
    drive(1'b1, 5'd0, 1'b1, 5'd1, 32'h0BADF00D, 4'hF);
    #13;
    chk("rst_rd_gnt", {31'b0, rd_gnt}, 32'd0);
    chk("rst_wr_gnt", {31'b0, wr_gnt}, 32'd0);
    chk("rst_scm_ren", {31'b0, scm_ren}, 32'd0);
    chk("rst_scm_wen", {31'b0, scm_wen}, 32'd0);
    chk("rst_rvalid", {31'b0, rd_rvalid}, 32'd0);
    chk("rst_rdata", rd_rdata, 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    expect_read();
    @(negedge clk);
    chk("first_rd_gnt", {31'b0, rd_gnt}, 32'd1);
    chk("first_wr_gnt", {31'b0, wr_gnt}, 32'd1);
    tick();
    idle(4);

    // Write then read: response two cycles after the read grant.
    drive(1'b0, 5'd0, 1'b1, 5'd3, 32'hDEADBEEF, 4'hF);
    @(negedge clk); chk("lat_wen", {31'b0, scm_wen}, 32'd1);
    tick();
    drive(1'b1, 5'd3, 1'b0, 5'd0, 32'h0, 4'h0);
    expect_read();
    @(negedge clk); chk("lat_gnt", {31'b0, rd_gnt}, 32'd1);
    tick();
    drive(1'b0, 5'd0, 1'b0, 5'd0, 32'h0, 4'h0);
    @(negedge clk); chk("lat_rvalid_n2", {31'b0, rd_rvalid}, 32'd0);
    tick();
    @(negedge clk);
    chk("lat_rvalid_n3", {31'b0, rd_rvalid}, 32'd1);
    chk("lat_rdata_n3", rd_rdata, 32'hDEADBEEF);
    tick();
    idle(3);

    // Table-driven single-cycle vectors, responses drained continuously.
    for (int i = 0; i < 9; i++) begin
      drive(vecs[i].rd_req, vecs[i].rd_add, vecs[i].wr_req, vecs[i].wr_add,
            vecs[i].wdata, vecs[i].be);
      if (vecs[i].exp_gnt) expect_read();
      @(negedge clk);
      chk($sformatf("v%0d_rd_gnt", i), {31'b0, rd_gnt}, {31'b0, vecs[i].exp_gnt});
      chk($sformatf("v%0d_scm_ren", i), {31'b0, scm_ren}, {31'b0, vecs[i].exp_gnt});
      chk($sformatf("v%0d_scm_raddr", i), {27'b0, scm_raddr},
          vecs[i].exp_gnt ? {27'b0, vecs[i].rd_add} : 32'd0);
      chk($sformatf("v%0d_wr_gnt", i), {31'b0, wr_gnt}, 32'd1);
      chk($sformatf("v%0d_scm_wen", i), {31'b0, scm_wen}, {31'b0, vecs[i].exp_wen});
      chk($sformatf("v%0d_scm_waddr", i), {27'b0, scm_waddr}, {27'b0, vecs[i].wr_add});
      chk($sformatf("v%0d_scm_wdata", i), scm_wdata, vecs[i].wdata);
      chk($sformatf("v%0d_scm_wbe", i), {28'b0, scm_wbe}, {28'b0, vecs[i].be});
      tick();
    end
    idle(4);

    // Back-to-back reads, one response per cycle.
    base = n_resp;
    for (int a = 0; a < 16; a++) begin
      drive(1'b1, 5'(a), 1'b0, 5'd0, 32'h0, 4'h0);
      expect_read();
      @(negedge clk);
      chk($sformatf("b2b_gnt_%0d", a), {31'b0, rd_gnt}, 32'd1);
      if (a >= 2) chk($sformatf("b2b_rvalid_%0d", a), {31'b0, rd_rvalid}, 32'd1);
      tick();
    end
    idle(4);
    chk("b2b_resp_count", 32'(n_resp - base), 32'd16);

    // Backpressure: only RESP_DEPTH reads accepted while rready is low.
    rd_rready = 1'b0;
    head20 = mem[20];
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, (i < 2) ? 5'(20 + i) : 5'd22, 1'b0, 5'd0, 32'h0, 4'h0);
      if (i < 2) expect_read();
      @(negedge clk);
      chk($sformatf("bp_gnt_%0d", i), {31'b0, rd_gnt}, (i < 2) ? 32'd1 : 32'd0);
      if (i >= 2) begin
        chk($sformatf("bp_rvalid_%0d", i), {31'b0, rd_rvalid}, 32'd1);
        chk($sformatf("bp_hold_data_%0d", i), rd_rdata, head20);
      end
      tick();
    end
    rd_rready = 1'b1;
    granted = 0;
    next_a = 22;
    for (int c = 0; c < 20 && next_a < 25; c++) begin
      drive(1'b1, 5'(next_a), 1'b0, 5'd0, 32'h0, 4'h0);
      @(negedge clk);
      if (rd_gnt) begin
        expect_read();
        granted++;
        next_a++;
      end
      tick();
    end
    chk("bp_remaining_grants", 32'(granted), 32'd3);
    idle(5);
    chk("bp_drained", 32'(exp_q.size()), 32'd0);

    // Reset with two responses queued.
    rd_rready = 1'b0;
    drive(1'b1, 5'd1, 1'b0, 5'd0, 32'h0, 4'h0);
    @(negedge clk); chk("mr_gnt0", {31'b0, rd_gnt}, 32'd1);
    tick();
    drive(1'b1, 5'd2, 1'b0, 5'd0, 32'h0, 4'h0);
    @(negedge clk); chk("mr_gnt1", {31'b0, rd_gnt}, 32'd1);
    tick();
    idle(2);
    @(negedge clk); chk("mr_queued_rvalid", {31'b0, rd_rvalid}, 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("mr_rvalid_in_reset", {31'b0, rd_rvalid}, 32'd0);
    chk("mr_rdata_in_reset", rd_rdata, 32'd0);
    tick();
    rst_n = 1'b1;
    rd_rready = 1'b1;
    idle(5);
    @(negedge clk);
    chk("mr_no_stale_rvalid", {31'b0, rd_rvalid}, 32'd0);
    chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
